// File: rtl/noc_local_deframer_if.sv
// AXI-Stream bundle used on both sides of noc_local_deframer.
// The master modport drives the beat; the slave modport drives TREADY.
interface noc_local_deframer_if #(
    parameter int BW = 32
) ();
    localparam int BWB = BW / 8;

    logic           TVALID;
    logic           TREADY;
    logic [BW-1:0]  TDATA;
    logic [BWB-1:0] TKEEP;
    logic           TLAST;

    modport master (
        output TVALID,
        output TDATA,
        output TKEEP,
        output TLAST,
        input  TREADY
    );

    modport slave (
        input  TVALID,
        input  TDATA,
        input  TKEEP,
        input  TLAST,
        output TREADY
    );
endinterface

// File: rtl/noc_local_deframer.sv
// Receive-side NoC deframer: filters packets by destination, strips the header and enforces
// the header length against TLAST. Define DEFRAMER_STATS_EN to build the saturating statistics.
module noc_local_deframer #(
    parameter int BW    = 32,
    parameter int XY_SZ = 3,
    parameter int LEN_W = 8
) (
    input  logic                 clk_line,
    input  logic                 clk_line_rst_low,
    input  logic [2*XY_SZ-1:0]   HsrcId,
    noc_local_deframer_if.slave  stream_in,
    noc_local_deframer_if.master stream_out,
    output logic [2*XY_SZ-1:0]   pkt_src,
    output logic [LEN_W-1:0]     pkt_len,
    output logic [3:0]           pkt_type,
    output logic                 busy,
    output logic [15:0]          pkt_cnt,
    output logic [15:0]          drop_cnt,
    output logic [15:0]          err_cnt
);
    localparam int BWB    = BW / 8;
    localparam int SRC_LO = 2 * XY_SZ;
    localparam int LEN_LO = 4 * XY_SZ;
    localparam int TYP_LO = 4 * XY_SZ + LEN_W;

    typedef enum logic [1:0] {
        HDR,
        PAYLOAD,
        DROP,
        FLUSH
    } state_t;

    state_t state, state_n;

    logic [LEN_W-1:0]   cnt, cnt_n;
    logic               out_valid;
    logic [BW-1:0]      out_data;
    logic [BWB-1:0]     out_keep;
    logic               out_last;

    logic               in_ready;
    logic               in_fire;
    logic               fwd;
    logic               fwd_last;
    logic               hdr_take;
    logic               pkt_inc;
    logic               drop_inc;
    logic               err_inc;

    logic [2*XY_SZ-1:0] hdr_dst;
    logic [2*XY_SZ-1:0] hdr_src;
    logic [LEN_W-1:0]   hdr_len;
    logic [3:0]         hdr_type;

    assign hdr_dst  = stream_in.TDATA[SRC_LO-1:0];
    assign hdr_src  = stream_in.TDATA[LEN_LO-1:SRC_LO];
    assign hdr_len  = stream_in.TDATA[TYP_LO-1:LEN_LO];
    assign hdr_type = stream_in.TDATA[TYP_LO+3:TYP_LO];

    // Discard states never touch the output slice, so they always accept.
    assign in_ready = (state == DROP || state == FLUSH) ? 1'b1
                    : (!out_valid || stream_out.TREADY);
    assign in_fire  = stream_in.TVALID && in_ready;

    assign stream_in.TREADY  = in_ready;
    assign stream_out.TVALID = out_valid;
    assign stream_out.TDATA  = out_data;
    assign stream_out.TKEEP  = out_keep;
    assign stream_out.TLAST  = out_last;
    assign busy              = (state != HDR);

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            state <= HDR;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        fwd      = 1'b0;
        fwd_last = 1'b0;
        hdr_take = 1'b0;
        pkt_inc  = 1'b0;
        drop_inc = 1'b0;
        err_inc  = 1'b0;
        case (state)
            HDR: begin
                if (in_fire) begin
                    if (stream_in.TLAST) begin
                        err_inc = 1'b1;
                    end else if (hdr_len == '0) begin
                        err_inc = 1'b1;
                        state_n = DROP;
                    end else if (hdr_dst != HsrcId) begin
                        drop_inc = 1'b1;
                        state_n  = DROP;
                    end else begin
                        hdr_take = 1'b1;
                        cnt_n    = hdr_len;
                        state_n  = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (in_fire) begin
                    fwd   = 1'b1;
                    cnt_n = cnt - LEN_W'(1);
                    // Input TLAST takes priority, so TLAST on the final counted beat is a clean end.
                    if (stream_in.TLAST) begin
                        fwd_last = 1'b1;
                        pkt_inc  = 1'b1;
                        err_inc  = (cnt != LEN_W'(1));
                        state_n  = HDR;
                    end else if (cnt == LEN_W'(1)) begin
                        fwd_last = 1'b1;
                        pkt_inc  = 1'b1;
                        err_inc  = 1'b1;
                        state_n  = FLUSH;
                    end
                end
            end
            DROP, FLUSH: begin
                if (in_fire && stream_in.TLAST) begin
                    state_n = HDR;
                end
            end
            default: state_n = HDR;
        endcase
    end

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (fwd) begin
            out_valid <= 1'b1;
            out_data  <= stream_in.TDATA;
            out_keep  <= stream_in.TKEEP;
            out_last  <= fwd_last;
        end else if (stream_out.TREADY) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            pkt_src  <= '0;
            pkt_len  <= '0;
            pkt_type <= '0;
        end else if (hdr_take) begin
            pkt_src  <= hdr_src;
            pkt_len  <= hdr_len;
            pkt_type <= hdr_type;
        end
    end

`ifdef DEFRAMER_STATS_EN
    logic [15:0] pkt_q;
    logic [15:0] drop_q;
    logic [15:0] err_q;

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            pkt_q  <= '0;
            drop_q <= '0;
            err_q  <= '0;
        end else begin
            if (pkt_inc && pkt_q != '1) pkt_q <= pkt_q + 16'd1;
            if (drop_inc && drop_q != '1) drop_q <= drop_q + 16'd1;
            if (err_inc && err_q != '1) err_q <= err_q + 16'd1;
        end
    end

    assign pkt_cnt  = pkt_q;
    assign drop_cnt = drop_q;
    assign err_cnt  = err_q;
`else
    logic unused_stats;
    assign unused_stats = ^{pkt_inc, drop_inc, err_inc};

    assign pkt_cnt  = '0;
    assign drop_cnt = '0;
    assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_noc_local_deframer.sv
// Directed self-checking bench for noc_local_deframer; counter expectations follow DEFRAMER_STATS_EN.
module tb_noc_local_deframer;
    localparam int BW = 32;
`ifdef DEFRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  hsrc;
    logic [5:0]  pkt_src;
    logic [7:0]  pkt_len;
    logic [3:0]  pkt_type;
    logic        busy;
    logic [15:0] pkt_cnt, drop_cnt, err_cnt;

    noc_local_deframer_if #(.BW(BW)) s_in ();
    noc_local_deframer_if #(.BW(BW)) s_out ();

    noc_local_deframer #(.BW(BW), .XY_SZ(3), .LEN_W(8)) dut (
        .clk_line         (clk),
        .clk_line_rst_low (rst_n),
        .HsrcId           (hsrc),
        .stream_in        (s_in),
        .stream_out       (s_out),
        .pkt_src          (pkt_src),
        .pkt_len          (pkt_len),
        .pkt_type         (pkt_type),
        .busy             (busy),
        .pkt_cnt          (pkt_cnt),
        .drop_cnt         (drop_cnt),
        .err_cnt          (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_pkt  = 0;
    int m_drop = 0;
    int m_err  = 0;

    logic [36:0] out_q[$];
    logic [36:0] exp_q[$];
    bit          rand_rdy  = 1'b0;
    logic        rdy_fixed = 1'b1;
    logic        stalled   = 1'b0;
    logic [36:0] stall_beat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [5:0] dst, input logic [5:0] src,
                                        input logic [7:0] len, input logic [3:0] typ);
        return {8'h00, typ, len, src, dst};
    endfunction

    // Drives one beat from a falling edge and returns on the falling edge after it is taken.
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, output int waits);
        bit acc;
        acc = 1'b0;
        waits = 0;
        s_in.TVALID = 1'b1;
        s_in.TDATA  = d;
        s_in.TKEEP  = k;
        s_in.TLAST  = l;
        for (int i = 0; i < 500; i++) begin
            #4;
            if (s_in.TREADY) begin
                acc = 1'b1;
                break;
            end
            waits++;
            @(negedge clk);
        end
        if (acc) @(negedge clk);
        s_in.TVALID = 1'b0;
        if (!acc) chk("accept_timeout", 64'(acc), 64'(1'b1));
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l, input bit expect_out);
        int w;
        send(d, k, l, w);
        if (expect_out) exp_q.push_back({k, l, d});
    endtask

    task automatic check_out(input string tag);
        for (int i = 0; i < 4000 && out_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            chk(tag, 64'(out_q[i]), 64'(exp_q[i]));
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_pkt_cnt"},  64'(pkt_cnt),  64'(STATS ? 16'(m_pkt)  : 16'd0));
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(STATS ? 16'(m_drop) : 16'd0));
        chk({tag, "_err_cnt"},  64'(err_cnt),  64'(STATS ? 16'(m_err)  : 16'd0));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out"}, 64'({s_out.TVALID, s_out.TKEEP, s_out.TLAST, s_out.TDATA}), 64'd0);
        chk({tag, "_meta"}, 64'({pkt_src, pkt_len, pkt_type}), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_cnts"}, 64'({pkt_cnt, drop_cnt, err_cnt}), 64'd0);
    endtask

    // Output side: pick TREADY on each falling edge, record handshakes, and check stall stability.
    initial begin
        s_out.TREADY = 1'b1;
        forever begin
            @(negedge clk);
            s_out.TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
            if (stalled)
                chk("stall_hold", 64'({s_out.TVALID, s_out.TKEEP, s_out.TLAST, s_out.TDATA}),
                    64'({1'b1, stall_beat}));
            if (s_out.TVALID && s_out.TREADY)
                out_q.push_back({s_out.TKEEP, s_out.TLAST, s_out.TDATA});
            stalled    = s_out.TVALID && !s_out.TREADY && rst_n;
            stall_beat = {s_out.TKEEP, s_out.TLAST, s_out.TDATA};
        end
    end

    initial begin
        int w;
        int wsum;
        hsrc        = 6'h09;
        s_in.TVALID = 1'b0;
        s_in.TDATA  = '0;
        s_in.TKEEP  = '0;
        s_in.TLAST  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Good packet for this tile
        send(hdr(6'h09, 6'h12, 8'd4, 4'd3), 4'hF, 1'b0, w);
        chk("busy_after_hdr", 64'(busy), 64'd1);
        beat(32'hA000_0001, 4'hF, 1'b0, 1'b1);
        beat(32'hA000_0002, 4'hF, 1'b0, 1'b1);
        beat(32'hA000_0003, 4'hF, 1'b0, 1'b1);
        beat(32'hA000_0004, 4'h3, 1'b1, 1'b1);
        m_pkt = 1;
        check_out("good_beat");
        chk("good_src",  64'(pkt_src),  64'h12);
        chk("good_len",  64'(pkt_len),  64'd4);
        chk("good_type", 64'(pkt_type), 64'd3);
        chk("good_busy", 64'(busy),     64'd0);
        chk_stats("good");

        // Packet for another tile is swallowed without stalling
        wsum = 0;
        send(hdr(6'h0A, 6'h12, 8'd3, 4'd1), 4'hF, 1'b0, w); wsum += w;
        chk("drop_busy", 64'(busy), 64'd1);
        send(32'hB000_0001, 4'hF, 1'b0, w); wsum += w;
        send(32'hB000_0002, 4'hF, 1'b0, w); wsum += w;
        send(32'hB000_0003, 4'hF, 1'b1, w); wsum += w;
        m_drop = 1;
        chk("drop_ready_waits", 64'(wsum), 64'd0);
        check_out("drop_beat");
        chk("drop_busy_end", 64'(busy), 64'd0);
        chk("drop_src_kept", 64'(pkt_src), 64'h12);
        chk_stats("drop");

        // Short packet: TLAST arrives early
        send(hdr(6'h09, 6'h05, 8'd5, 4'd7), 4'hF, 1'b0, w);
        beat(32'hC000_0001, 4'hF, 1'b0, 1'b1);
        beat(32'hC000_0002, 4'hF, 1'b1, 1'b1);
        m_pkt = 2; m_err = 1;
        check_out("short_beat");
        chk("short_meta", 64'({pkt_src, pkt_len, pkt_type}), 64'({6'h05, 8'd5, 4'd7}));
        chk("short_busy", 64'(busy), 64'd0);
        chk_stats("short");

        // Long packet: TLAST forced, tail flushed
        send(hdr(6'h09, 6'h06, 8'd2, 4'd2), 4'hF, 1'b0, w);
        send(32'hD000_0001, 4'hF, 1'b0, w);
        exp_q.push_back({4'hF, 1'b0, 32'hD000_0001});
        send(32'hD000_0002, 4'hF, 1'b0, w);
        exp_q.push_back({4'hF, 1'b1, 32'hD000_0002});
        chk("long_busy_flush", 64'(busy), 64'd1);
        beat(32'hD000_0003, 4'hF, 1'b0, 1'b0);
        beat(32'hD000_0004, 4'hF, 1'b1, 1'b0);
        send(hdr(6'h09, 6'h12, 8'd1, 4'd1), 4'hF, 1'b0, w);
        beat(32'hE000_0001, 4'h1, 1'b1, 1'b1);
        m_pkt = 4; m_err = 2;
        check_out("long_beat");
        chk("long_next_len", 64'(pkt_len), 64'd1);
        chk_stats("long");

        // Runt header and zero-length header
        send(hdr(6'h09, 6'h33, 8'd3, 4'd9), 4'hF, 1'b1, w);
        m_err = 3;
        @(negedge clk);
        chk("runt_busy", 64'(busy), 64'd0);
        chk("runt_meta_kept", 64'(pkt_len), 64'd1);
        send(hdr(6'h09, 6'h12, 8'd0, 4'd5), 4'hF, 1'b0, w);
        chk("len0_busy", 64'(busy), 64'd1);
        beat(32'hF000_0001, 4'hF, 1'b1, 1'b0);
        m_err = 4;
        check_out("len0_beat");
        chk("len0_busy_end", 64'(busy), 64'd0);
        chk_stats("errs");

        // Back-to-back packets with random backpressure
        rand_rdy = 1'b1;
        for (int p = 0; p < 100; p++) begin
            send(hdr(6'h09, 6'h12, 8'd8, 4'd4), 4'hF, 1'b0, w);
            for (int b = 0; b < 8; b++)
                beat({8'h5A, 8'(p), 8'(b), 8'hC3}, 4'hF, (b == 7), 1'b1);
        end
        m_pkt += 100;
        for (int i = 0; i < 4000 && out_q.size() < exp_q.size(); i++) @(negedge clk);
        rand_rdy = 1'b0;
        check_out("rand_beat");
        chk_stats("rand");

        // Reset in the middle of a packet
        send(hdr(6'h09, 6'h21, 8'd6, 4'd9), 4'hF, 1'b0, w);
        send(32'h7700_0001, 4'hF, 1'b0, w);
        send(32'h7700_0002, 4'hF, 1'b0, w);
        s_in.TVALID = 1'b1;
        s_in.TDATA  = 32'h7700_0003;
        s_in.TKEEP  = 4'hF;
        s_in.TLAST  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        s_in.TVALID = 1'b0;
        rst_n = 1'b1;
        out_q.delete();
        exp_q.delete();
        m_pkt = 0; m_drop = 0; m_err = 0;
        @(negedge clk);
        send(hdr(6'h09, 6'h12, 8'd2, 4'd1), 4'hF, 1'b0, w);
        beat(32'h8800_0001, 4'hF, 1'b0, 1'b1);
        beat(32'h8800_0002, 4'hF, 1'b1, 1'b1);
        m_pkt = 1;
        check_out("post_rst_beat");
        chk_stats("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/noc_local_deframer.md
# noc_local_deframer

Receive-side stage between the tile switch's local output port and the FFT accelerator's stream input. Parses the one-beat NoC header of each packet arriving from the switch, drops packets not addressed to this tile, strips the header, and forwards payload beats with packet metadata (source, length, type) held stable on sideband outputs. It enforces the header length field against TLAST, so the accelerator always sees well-framed packets.

## Interface
- BW, 32, stream data width; must be ≥ 32.
- BWB, BW/8, TKEEP width.
- XY_SZ, 3, width of one tile coordinate.
- LEN_W, 8, header length-field width; equals NOC_BUFFER_ADDR_W.
- clk_line  in  1  line clock; all logic on the rising edge.
- clk_line_rst_low  in  1  asynchronous, active-low reset.
- HsrcId  in  2*XY_SZ  this tile's {Y,X}; quasi-static.
- stream_in_TVALID / TDATA / TKEEP / TLAST  in  1/BW/BWB/1  AXI-Stream from the switch local out.
- stream_in_TREADY  out  1  ready to the switch.
- stream_out_TVALID / TDATA / TKEEP / TLAST  out  1/BW/BWB/1  payload to the accelerator.
- stream_out_TREADY  in  1  accelerator ready.
- pkt_src  out  2*XY_SZ  source {Y,X} of the current packet.
- pkt_len  out  LEN_W  payload beat count from the header.
- pkt_type  out  4  header type field.
- busy  out  1  high whenever the state is not HDR.
- pkt_cnt, drop_cnt, err_cnt  out  16 each  saturating statistics.

## Operation
- Header beat layout: [2*XY_SZ-1:0] destination {Y,X}; [4*XY_SZ-1:2*XY_SZ] source; [4*XY_SZ+LEN_W-1:4*XY_SZ] length; next 4 bits type; remaining bits ignored. Defaults: dst [5:0], src [11:6], len [19:12], type [23:20].
- FSM states: HDR, PAYLOAD, DROP, FLUSH. Reset state is HDR.
- HDR: accept one beat.
  - Beat with TLAST=1 (runt): err_cnt+1, stay in HDR.
  - len==0 and no TLAST: err_cnt+1, go to DROP.
  - Destination ≠ HsrcId: drop_cnt+1, go to DROP.
  - Otherwise: latch src/len/type, load the beat counter with len, go to PAYLOAD.
- PAYLOAD: each accepted beat is forwarded unchanged except TLAST, and the counter decrements.
  - Counter==1 and input TLAST=1: normal end. Output TLAST=1, pkt_cnt+1, go to HDR.
  - Input TLAST=1 with counter>1 (short packet): output TLAST=1, err_cnt+1, pkt_cnt+1, go to HDR.
  - Counter==1 with input TLAST=0 (long packet): output TLAST forced to 1, err_cnt+1, pkt_cnt+1, go to FLUSH.
- DROP and FLUSH: stream_in_TREADY=1 and beats are discarded. The beat with TLAST returns the FSM to HDR. No output is produced.
- pkt_src, pkt_len and pkt_type change only on header acceptance and stay stable through PAYLOAD.
- Counters saturate at 16'hFFFF.

## Timing
- The output is a registered slice: stream_in_TREADY = !stream_out_TVALID || stream_out_TREADY in PAYLOAD, 1 in DROP/FLUSH, and the same expression in HDR.
- Payload latency is 1 cycle from input acceptance to stream_out_TVALID. Full throughput is one beat per cycle.
- A header costs one input cycle and produces no output. Back-to-back packets need no idle cycle.
- Once stream_out_TVALID is asserted, it and TDATA/TKEEP/TLAST stay stable until TREADY; no combinational path exists from stream_in_TVALID to the outputs.
- Counter and metadata updates are visible on the cycle after the triggering handshake.
- Reset values: stream_out_TVALID=0, TDATA=0, TKEEP=0, TLAST=0, pkt_src=0, pkt_len=0, pkt_type=0, busy=0, all counters=0, state HDR.
- Reset asserted mid-packet aborts immediately. After release the block waits for a header, so the remainder of an interrupted packet is parsed as headers; upstream must reset together with this block.
- If an input TLAST and the forced-TLAST condition occur on the same beat, this is a normal end.

## Configuration
- DEFRAMER_STATS_EN: when defined, pkt_cnt, drop_cnt and err_cnt are implemented as described.
- When not defined, all three outputs are tied to 0, no counter flops are built, and framing behaviour is identical.

## Test plan
- HsrcId=6'h09, header dst=6'h09, src=6'h12, len=4, type=3, then 4 payload beats with TLAST on the 4th -> 4 output beats with identical data, TLAST only on the 4th, pkt_src=6'h12, pkt_len=4, pkt_type=3, pkt_cnt=1.
- Header dst=6'h0A with 3 payload beats -> no stream_out_TVALID, drop_cnt=1, TREADY high throughout, FSM back in HDR after TLAST.
- len=5 but TLAST on the 2nd payload beat -> 2 output beats with TLAST on the 2nd, err_cnt=1.
- len=2 with TLAST on the 4th beat -> 2 output beats with forced TLAST, beats 3–4 discarded, err_cnt=1; the next good packet passes.
- Random stream_out_TREADY (50%) over 100 back-to-back 8-beat packets -> no loss or duplication, output data stable while stalled, pkt_cnt=100.
- Reset pulse during beat 3 of 6 -> all outputs at reset values next cycle; without DEFRAMER_STATS_EN the counters read 0 throughout.
